fetch_unit: RTL and testbench

- Instruction fetch front-end between the core's decode stage and the instruction RAM.
- Owns the fetch PC and drives the instruction RAM request/valid handshake with at most one request outstanding.
- Buffers returned words with their PCs in a small FIFO and presents them to decode on a valid/ready interface.
- Handles redirects (branch, jump, trap) by flushing buffered words and dropping any in-flight response.

---
 rtl/fetch_pkg.sv | 23 ++
 rtl/fetch_fifo.sv | 78 +++++++
 rtl/fetch_unit.sv | 129 ++++++++++++
 tb/tb_fetch_unit.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch front-end.
//   fetch_state_e : fetch controller states
//   fetch_entry_t : one buffered instruction together with its fetch PC
//   INSTR_W       : instruction word width
//   NOP_INSTR     : canonical NOP the core inserts into flushed decode slots
package fetch_pkg;

  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD,
    DRAIN
  } fetch_state_e;

  typedef struct packed {
    logic [31:0]        pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of {pc, instr} entries.
//   clk, rst   : clock, asynchronous active-low reset
//   push       : write push_entry at the tail
//   push_entry : entry to write
//   pop        : drop the head entry
//   flush      : empty the FIFO; has priority over push and pop
//   count      : number of valid entries (0..DEPTH)
//   head       : entry at the head (meaningful only when count != 0)
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  fetch_entry_t           push_entry,
  input  logic                   pop,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] count,
  output fetch_entry_t           head
);

  localparam int PTR_W = $clog2(DEPTH);

  fetch_entry_t mem [DEPTH];

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    do_push  = push && !flush;
    do_pop   = pop && !flush && (count_q != '0);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;

    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; an entry is only observed after count marks it valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_entry;
  end

  assign count = count_q;
  assign head  = mem[rd_ptr_q];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front-end between decode and the instruction RAM.
//   clk, rst        : clock, asynchronous active-low reset
//   imem_request    : request to instruction RAM (at most one outstanding)
//   imem_addr       : word address, stable while a request is outstanding
//   imem_rdata      : returned instruction, qualified by imem_valid
//   imem_valid      : one-cycle pulse completing the outstanding request
//   redirect_valid  : branch/jump/trap redirect this cycle
//   redirect_pc     : redirect target (bits [1:0] ignored)
//   if_valid        : head of the instruction buffer is valid
//   if_instr, if_pc : head instruction and its PC (zero when not valid)
//   id_ready        : decode consumes the head when if_valid && id_ready
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          ADDR_W     = 8,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_request,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_valid,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [31:0]        if_pc,
  input  logic               id_ready
);

  localparam int               CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL  = CNT_W'(FIFO_DEPTH);

  fetch_state_e      state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [ADDR_W-1:0] drain_addr_q, drain_addr_d;

  logic [CNT_W-1:0]  count, count_after;
  fetch_entry_t      head, push_entry;
  logic              push, pop, flush;

  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // The decode slot in a redirect cycle is discarded by the core, so no pop then.
  assign pop = if_valid && id_ready && !redirect_valid;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    imem_request = 1'b0;
    imem_addr    = pc_q[ADDR_W+1:2];
    push         = 1'b0;
    flush        = 1'b0;
    push_entry   = '{pc: pc_q, instr: imem_rdata};
    // Occupancy after a push this cycle; only consulted when pushing.
    count_after  = count + CNT_W'(1) - CNT_W'(pop);

    case (state_q)
      IDLE: state_d = FETCH;

      FETCH: begin
        imem_request = 1'b1;
        if (redirect_valid) begin
          // A word returning in the redirect cycle is stale; otherwise the
          // outstanding request must still be drained at its original address.
          state_d      = imem_valid ? FETCH : DRAIN;
          drain_addr_d = pc_q[ADDR_W+1:2];
        end else if (imem_valid) begin
          push    = 1'b1;
          pc_d    = pc_q + 32'd4;
          state_d = (count_after == FULL) ? HOLD : FETCH;
        end
      end

      HOLD: begin
        if (redirect_valid || count < FULL) state_d = FETCH;
      end

      DRAIN: begin
        imem_request = 1'b1;
        imem_addr    = drain_addr_q;
        // The drained response completes the old request even if another
        // redirect lands in the same cycle; that redirect only moves pc_q.
        if (imem_valid) state_d = FETCH;
      end

      default: state_d = IDLE;
    endcase

    if (redirect_valid && state_q != IDLE) begin
      flush = 1'b1;
      pc_d  = {redirect_pc[31:2], 2'b00};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      drain_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (flush),
    .count      (count),
    .head       (head)
  );

  assign if_valid = (count != '0);
  assign if_instr = if_valid ? head.instr : '0;
  assign if_pc    = if_valid ? head.pc    : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit. A memory responder serves requests
// with configurable latency; the reference model is the expected instruction
// stream: sequential PCs from reset/redirect target, instr = memory word.
`timescale 1ns/1ps
module tb_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        imem_request;
  logic [7:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_ready;

  logic        w_request;
  logic [7:0]  w_addr;
  logic [31:0] w_rdata;
  logic        w_valid;
  logic        w_redirect_valid = 1'b0;
  logic [31:0] w_redirect_pc    = 32'h0;
  logic        w_if_valid;
  logic [31:0] w_if_instr;
  logic [31:0] w_if_pc;
  logic        w_id_ready       = 1'b1;

  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .imem_request   (imem_request),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .imem_valid     (imem_valid),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .id_ready       (id_ready)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk            (clk),
    .rst            (rst),
    .imem_request   (w_request),
    .imem_addr      (w_addr),
    .imem_rdata     (w_rdata),
    .imem_valid     (w_valid),
    .redirect_valid (w_redirect_valid),
    .redirect_pc    (w_redirect_pc),
    .if_valid       (w_if_valid),
    .if_instr       (w_if_instr),
    .if_pc          (w_if_pc),
    .id_ready       (w_id_ready)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] mem_words [256];
  int          lat_mode = 1;        // fixed latency, or -1 for random 0..3
  logic [7:0]  served[$];           // addresses completed by the responder
  logic [31:0] consumed[$];         // PCs accepted by decode
  logic [31:0] exp_pc = 32'h0;
  logic        cap_valid = 1'b0;
  logic [31:0] cap_pc = 32'h0;
  logic [31:0] cap_instr = 32'h0;
  logic        chk_after_redirect = 1'b0;

  // Memory responder for the main DUT.
  initial begin : responder
    int         waited;
    int         cur_lat;
    logic [7:0] start_addr;
    waited = 0; cur_lat = 0; start_addr = 8'h0;
    imem_valid = 1'b0; imem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      imem_valid = 1'b0;
      if (!rst || !imem_request) begin
        waited = 0;
      end else begin
        if (waited == 0) begin
          start_addr = imem_addr;
          cur_lat    = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
        end else begin
          n_checks++;
          if (imem_addr !== start_addr) begin
            n_fail++;
            $display("FAIL addr_stable: imem_addr=%h required %h", imem_addr, start_addr);
          end
        end
        if (waited >= cur_lat) begin
          imem_valid = 1'b1;
          imem_rdata = mem_words[imem_addr];
          served.push_back(imem_addr);
          waited = 0;
        end else begin
          waited++;
        end
      end
    end
  end

  // Zero-latency responder for the wrap-around DUT.
  initial begin : responder_wrap
    w_valid = 1'b0; w_rdata = 32'h0;
    forever begin
      @(negedge clk);
      w_valid = rst && w_request;
      w_rdata = mem_words[w_addr];
    end
  end

  // Capture DUT outputs mid-cycle; check if_valid the cycle after a redirect.
  initial begin : capture
    forever begin
      @(negedge clk);
      cap_valid = if_valid;
      cap_pc    = if_pc;
      cap_instr = if_instr;
      if (chk_after_redirect) begin
        chk_after_redirect = 1'b0;
        n_checks++;
        if (if_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL valid_after_redirect: if_valid=%b required 0", if_valid);
        end
      end
    end
  end

  // Stream scoreboard: every consumed word must be the next expected PC.
  initial begin : scoreboard
    forever begin
      @(posedge clk);
      if (!rst) begin
        exp_pc = 32'h0;
      end else if (redirect_valid) begin
        exp_pc = {redirect_pc[31:2], 2'b00};
        chk_after_redirect = 1'b1;
      end else if (cap_valid && id_ready) begin
        n_checks++;
        if (cap_pc !== exp_pc || cap_instr !== mem_words[exp_pc[9:2]]) begin
          n_fail++;
          $display("FAIL stream: if_pc=%h if_instr=%h required pc=%h instr=%h",
                   cap_pc, cap_instr, exp_pc, mem_words[exp_pc[9:2]]);
        end
        consumed.push_back(cap_pc);
        exp_pc = exp_pc + 32'd4;
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic apply_reset(input int lat, input logic ready);
    tick(1);
    rst = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    id_ready = ready; lat_mode = lat;
    tick(2);
    rst = 1'b1;
    served.delete();
    consumed.delete();
  endtask

  task automatic wait_request(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (imem_request) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    tick(1);
    rst = 1'b0;
    #1;
    n_checks++;
    if (imem_request !== 1'b0 || if_valid !== 1'b0 || if_instr !== 32'h0 || if_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: req=%b valid=%b instr=%h pc=%h required all 0",
               imem_request, if_valid, if_instr, if_pc);
    end
    tick(2);
    rst = 1'b1;
    #1;
    n_checks++;
    if (imem_request !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_no_request: imem_request=%b required 0", imem_request);
    end
    tick(1);
    n_checks++;
    if (imem_request !== 1'b1 || imem_addr !== 8'h00) begin
      n_fail++;
      $display("FAIL first_request: req=%b addr=%h required 1 / 00", imem_request, imem_addr);
    end
  endtask

  task automatic test_sequential();
    logic [7:0]  exp_a [3] = '{8'h00, 8'h01, 8'h02};
    logic [31:0] exp_p [3] = '{32'h0, 32'h4, 32'h8};
    apply_reset(1, 1'b1);
    tick(12);
    n_checks++;
    if (served.size() < 3 || consumed.size() < 3) begin
      n_fail++;
      $display("FAIL seq_progress: served=%0d consumed=%0d required >=3", served.size(), consumed.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (served[i] !== exp_a[i] || consumed[i] !== exp_p[i]) begin
          n_fail++;
          $display("FAIL seq_%0d: addr=%h pc=%h required %h / %h", i, served[i], consumed[i], exp_a[i], exp_p[i]);
        end
      end
    end
  endtask

  task automatic test_hold();
    apply_reset(0, 1'b0);
    tick(10);
    n_checks++;
    if (served.size() != 2 || imem_request !== 1'b0 || if_valid !== 1'b1 || if_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL hold: served=%0d req=%b valid=%b pc=%h required 2 / 0 / 1 / 0",
               served.size(), imem_request, if_valid, if_pc);
    end
    id_ready = 1'b1;
    tick(10);
    n_checks++;
    if (served.size() < 3 || consumed.size() < 3) begin
      n_fail++;
      $display("FAIL hold_resume_progress: served=%0d consumed=%0d required >=3", served.size(), consumed.size());
    end else if (served[2] !== 8'h02 || consumed[0] !== 32'h0 || consumed[2] !== 32'h8) begin
      n_fail++;
      $display("FAIL hold_resume: addr=%h pc0=%h pc2=%h required 02 / 0 / 8", served[2], consumed[0], consumed[2]);
    end
  endtask

  task automatic test_drain();
    bit ok;
    apply_reset(3, 1'b1);
    wait_request(ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL drain_timeout: imem_request=%b required 1", imem_request);
    end
    @(posedge clk); #1;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0043;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    tick(1);
    n_checks++;
    if (imem_request !== 1'b1 || imem_addr !== 8'h00) begin
      n_fail++;
      $display("FAIL drain_hold_addr: req=%b addr=%h required 1 / 00", imem_request, imem_addr);
    end
    tick(20);
    n_checks++;
    if (served.size() < 2 || consumed.size() < 1) begin
      n_fail++;
      $display("FAIL drain_progress: served=%0d consumed=%0d required >=2 / >=1", served.size(), consumed.size());
    end else if (served[0] !== 8'h00 || served[1] !== 8'h10 || consumed[0] !== 32'h40) begin
      n_fail++;
      $display("FAIL drain_target: addr0=%h addr1=%h pc=%h required 00 / 10 / 40", served[0], served[1], consumed[0]);
    end
  endtask

  task automatic test_redirect_with_valid();
    bit          found;
    logic [31:0] tgt;
    found = 1'b0;
    tgt   = $urandom;
    apply_reset(2, 1'b0);
    for (int i = 0; i < 30; i++) begin
      tick(1);
      if (imem_valid && if_valid) begin found = 1'b1; break; end
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL rdv_timeout: imem_valid=%b if_valid=%b required 1 / 1", imem_valid, if_valid);
    end
    redirect_valid = 1'b1; redirect_pc = tgt;
    @(posedge clk); #1;
    redirect_valid = 1'b0; id_ready = 1'b1;
    n_checks++;
    if (if_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rdv_flush: if_valid=%b required 0", if_valid);
    end
    tick(15);
    n_checks++;
    if (consumed.size() < 1 || consumed[0] !== {tgt[31:2], 2'b00}) begin
      n_fail++;
      $display("FAIL rdv_target: consumed=%0d pc=%h required pc %h",
               consumed.size(), (consumed.size() > 0) ? consumed[0] : 32'h0, {tgt[31:2], 2'b00});
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_p [3] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    logic [7:0]  exp_w [3] = '{8'hFE, 8'hFF, 8'h00};
    logic [31:0] got_p [3];
    logic [31:0] got_i [3];
    int          got;
    got = 0;
    apply_reset(1, 1'b1);
    for (int i = 0; i < 20 && got < 3; i++) begin
      tick(1);
      if (w_if_valid) begin
        got_p[got] = w_if_pc;
        got_i[got] = w_if_instr;
        got++;
      end
    end
    n_checks++;
    if (got != 3) begin
      n_fail++;
      $display("FAIL wrap_progress: got=%0d required 3", got);
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (got_p[i] !== exp_p[i] || got_i[i] !== mem_words[exp_w[i]]) begin
          n_fail++;
          $display("FAIL wrap_%0d: pc=%h instr=%h required %h / %h",
                   i, got_p[i], got_i[i], exp_p[i], mem_words[exp_w[i]]);
        end
      end
    end
  endtask

  task automatic test_reset_in_drain();
    bit ok;
    apply_reset(5, 1'b1);
    wait_request(ok);
    @(posedge clk); #1;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0080;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    tick(1);
    n_checks++;
    if (!ok || imem_request !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_drain_setup: ok=%b req=%b required 1 / 1", ok, imem_request);
    end
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if (imem_request !== 1'b0 || if_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_async: req=%b valid=%b required 0 / 0", imem_request, if_valid);
    end
    tick(2);
    rst = 1'b1;
    served.delete();
    consumed.delete();
    tick(20);
    n_checks++;
    if (served.size() < 1 || consumed.size() < 1 || served[0] !== 8'h00 || consumed[0] !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_restart: served=%0d consumed=%0d required restart at addr 00 / pc 0",
               served.size(), consumed.size());
    end
  endtask

  task automatic test_random();
    apply_reset(-1, 1'b1);
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      id_ready       = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 24) == 0);
      redirect_pc    = $urandom;
    end
    redirect_valid = 1'b0;
    id_ready       = 1'b1;
    tick(10);
    n_checks++;
    if (consumed.size() < 200) begin
      n_fail++;
      $display("FAIL random_progress: consumed=%0d required >=200", consumed.size());
    end
  endtask

  initial begin : main
    rst = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; id_ready = 1'b1;
    for (int i = 0; i < 256; i++) mem_words[i] = $urandom;
    test_reset();
    test_sequential();
    test_hold();
    test_drain();
    test_redirect_with_valid();
    test_wrap();
    test_reset_in_drain();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
